ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs,
//  0xFF reset) to the keyboard over the shared ps2_c/ps2_d open-drain lines.

---
 rtl/ps2_host_tx_if.sv | 19 +
 rtl/ps2_host_tx.sv | 224 ++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a requester and the PS/2 host transmitter.
// master: tx_data/tx_valid out, tx_ready in; slave: the reverse.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, 8-bit
// odd-parity frame, device ACK check, with start/transfer timeouts.
// Ports: clk, rstn (async, active low), tx (slave: tx_data/tx_valid/tx_ready),
//   ps2_c_in/ps2_d_in (async pads), ps2_c_oe/ps2_d_oe (1 = pull low),
//   busy, tx_done, tx_err, err_code (01 start, 10 xfer, 11 no ACK).
// Option: define PS2_TX_RETRY_EN to retry start timeout / no-ACK failures.
module ps2_host_tx #(
  parameter int unsigned CLK_FREQ_HZ      = 100_000_000,
  parameter int unsigned INHIBIT_US       = 100,
  parameter int unsigned START_TIMEOUT_US = 15000,
  parameter int unsigned XFER_TIMEOUT_US  = 2000
`ifdef PS2_TX_RETRY_EN
  , parameter int unsigned RETRY_MAX      = 3
`endif
) (
  input  logic         clk,
  input  logic         rstn,
  ps2_host_tx_if.slave tx,
  input  logic         ps2_c_in,
  input  logic         ps2_d_in,
  output logic         ps2_c_oe,
  output logic         ps2_d_oe,
  output logic         busy,
  output logic         tx_done,
  output logic         tx_err,
  output logic [1:0]   err_code
);

  localparam int unsigned CPU   = CLK_FREQ_HZ / 1_000_000;
  localparam int unsigned INH_N = INHIBIT_US * CPU;
  localparam int unsigned STA_N = START_TIMEOUT_US * CPU;
  localparam int unsigned XFR_N = XFER_TIMEOUT_US * CPU;
  localparam int unsigned TMR_M = (INH_N > STA_N) ? INH_N : STA_N;
  localparam int TW = $clog2(TMR_M + 1);
  localparam int XW = $clog2(XFR_N + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INH,
    S_RTS,
    S_SHIFT,
    S_ACK,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [XW-1:0] xfer_q, xfer_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic          par_q, par_d;
  logic [1:0]    err_q, err_d;
  logic          c_oe_q, c_oe_d;
  logic          d_oe_q, d_oe_d;
  logic          c_s1_q, c_s2_q, c_s3_q;
  logic          d_s1_q, d_s2_q;
  logic          fall;
  logic          fail;
  logic [1:0]    fail_code;
`ifdef PS2_TX_RETRY_EN
  localparam int RW = $clog2(RETRY_MAX + 1);
  logic [RW-1:0] retry_q, retry_d;
`endif

  assign fall = c_s3_q & ~c_s2_q;

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    xfer_d    = xfer_q;
    bit_d     = bit_q;
    data_d    = data_q;
    par_d     = par_q;
    err_d     = err_q;
    d_oe_d    = d_oe_q;
    fail      = 1'b0;
    fail_code = 2'b00;
`ifdef PS2_TX_RETRY_EN
    retry_d   = retry_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (tx.tx_valid) begin
          data_d  = tx.tx_data;
          par_d   = ~^tx.tx_data;
          tmr_d   = '0;
          d_oe_d  = 1'b0;
          state_d = S_INH;
`ifdef PS2_TX_RETRY_EN
          retry_d = '0;
`endif
        end
      end
      S_INH: begin
        // start bit goes out during the final inhibit cycle
        if (tmr_q == TW'(INH_N - 2)) d_oe_d = 1'b1;
        if (tmr_q == TW'(INH_N - 1)) begin
          tmr_d   = '0;
          state_d = S_RTS;
        end else begin
          tmr_d = (&tmr_q) ? tmr_q : tmr_q + TW'(1);
        end
      end
      S_RTS: begin
        if (fall) begin
          d_oe_d  = ~data_q[0];
          bit_d   = 4'd1;
          xfer_d  = '0;
          state_d = S_SHIFT;
        end else if (tmr_q == TW'(STA_N - 1)) begin
          fail      = 1'b1;
          fail_code = 2'b01;
        end else begin
          tmr_d = (&tmr_q) ? tmr_q : tmr_q + TW'(1);
        end
      end
      S_SHIFT, S_ACK, S_WAIT: begin
        xfer_d = (&xfer_q) ? xfer_q : xfer_q + XW'(1);
        if (xfer_q == XW'(XFR_N - 1)) begin
          err_d   = 2'b10;
          state_d = S_ERR;
        end else if (state_q == S_SHIFT) begin
          if (fall) begin
            bit_d = (&bit_q) ? bit_q : bit_q + 4'd1;
            if (bit_q < 4'd8) begin
              d_oe_d = ~data_q[bit_q[2:0]];
            end else if (bit_q == 4'd8) begin
              d_oe_d = ~par_q;
            end else begin
              d_oe_d  = 1'b0;
              state_d = S_ACK;
            end
          end
        end else if (state_q == S_ACK) begin
          if (fall) begin
            if (d_s2_q) begin
              fail      = 1'b1;
              fail_code = 2'b11;
            end else begin
              state_d = S_WAIT;
            end
          end
        end else if (c_s2_q && d_s2_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (fail) begin
`ifdef PS2_TX_RETRY_EN
      if (retry_q != RW'(RETRY_MAX)) begin
        retry_d = retry_q + RW'(1);
        tmr_d   = '0;
        d_oe_d  = 1'b0;
        state_d = S_INH;
      end else begin
        err_d   = fail_code;
        state_d = S_ERR;
      end
`else
      err_d   = fail_code;
      state_d = S_ERR;
`endif
    end

    // pad enables are registered off the next state so they never glitch
    c_oe_d = (state_d == S_INH);
    if (!(state_d inside {S_INH, S_RTS, S_SHIFT})) d_oe_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      xfer_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      err_q   <= 2'b00;
      c_oe_q  <= 1'b0;
      d_oe_q  <= 1'b0;
      c_s1_q  <= 1'b1;
      c_s2_q  <= 1'b1;
      c_s3_q  <= 1'b1;
      d_s1_q  <= 1'b1;
      d_s2_q  <= 1'b1;
`ifdef PS2_TX_RETRY_EN
      retry_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      xfer_q  <= xfer_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      par_q   <= par_d;
      err_q   <= err_d;
      c_oe_q  <= c_oe_d;
      d_oe_q  <= d_oe_d;
      c_s1_q  <= ps2_c_in;
      c_s2_q  <= c_s1_q;
      c_s3_q  <= c_s2_q;
      d_s1_q  <= ps2_d_in;
      d_s2_q  <= d_s1_q;
`ifdef PS2_TX_RETRY_EN
      retry_q <= retry_d;
`endif
    end
  end

  assign ps2_c_oe    = c_oe_q;
  assign ps2_d_oe    = d_oe_q;
  assign tx.tx_ready = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign tx_done     = (state_q == S_DONE);
  assign tx_err      = (state_q == S_ERR);
  assign err_code    = (state_q == S_ERR) ? err_q : 2'b00;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: device model on an open-drain bus, frame model,
// per-cycle invariant checks and directed scenarios.
module tb_ps2_host_tx;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  ps2_host_tx_if tx_if ();

  logic       c_oe, d_oe, busy, done, err;
  logic [1:0] code;
  logic       dev_c_low = 1'b0;
  logic       dev_d_low = 1'b0;
  logic       c_line, d_line;

  assign c_line = !(c_oe || dev_c_low);
  assign d_line = !(d_oe || dev_d_low);

  ps2_host_tx #(.CLK_FREQ_HZ(1_000_000)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .tx       (tx_if.slave),
    .ps2_c_in (c_line),
    .ps2_d_in (d_line),
    .ps2_c_oe (c_oe),
    .ps2_d_oe (d_oe),
    .busy     (busy),
    .tx_done  (done),
    .tx_err   (err),
    .err_code (code)
  );

`ifdef PS2_TX_RETRY_EN
  localparam int TRIES = 4;
`else
  localparam int TRIES = 1;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // frame as the device sees it: 8 data bits LSB first, odd parity, stop
  function automatic logic [9:0] frame_of(input logic [7:0] b);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b};
  endfunction

  int         inh_run = 0, inh_cnt = 0, last_inh = 0, t_rts = 0;
  int         done_cnt = 0, err_cnt = 0, t_err = 0;
  logic [1:0] last_code = 2'b00;
  logic       prev_done = 1'b0, prev_err = 1'b0;

  always @(negedge clk) begin
    chk("ready_vs_busy", {31'd0, tx_if.tx_ready}, {31'd0, !busy});
    if (!busy) chk("idle_lines", {30'd0, c_oe, d_oe}, 0);
    if (!err) chk("code_quiet", {30'd0, code}, 0);
    chk("done_err_excl", {31'd0, done & err}, 0);
    chk("done_1cyc", {31'd0, prev_done & done}, 0);
    chk("err_1cyc", {31'd0, prev_err & err}, 0);
    prev_done <= done;
    prev_err  <= err;
    if (c_oe) begin
      inh_run <= inh_run + 1;
    end else if (inh_run > 0) begin
      last_inh <= inh_run;
      inh_cnt  <= inh_cnt + 1;
      inh_run  <= 0;
      t_rts    <= cyc;
    end
    if (done) done_cnt <= done_cnt + 1;
    if (err) begin
      err_cnt   <= err_cnt + 1;
      last_code <= code;
      t_err     <= cyc;
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    tx_if.tx_data  = b;
    tx_if.tx_valid = 1'b1;
    @(negedge clk);
    tx_if.tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max, input string nm);
    int n;
    n = 0;
    while (busy && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(nm, {31'd0, busy}, 0);
  endtask

  // keyboard: wait for request-to-send, clock nclk pulses at 10 kHz,
  // sample host data before each rising edge, ACK on pulse 11 if asked
  task automatic dev_frame(input bit ack, input int nclk,
                           output logic [9:0] bits, output int t1,
                           output bit ok);
    int n;
    ok = 1'b1;
    bits = '0;
    t1 = 0;
    n = 0;
    while (c_line !== 1'b0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (c_line !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    n = 0;
    while (!(c_line === 1'b1 && d_line === 1'b0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!(c_line === 1'b1 && d_line === 1'b0)) begin
      ok = 1'b0;
      return;
    end
    repeat (30) @(negedge clk);
    for (int i = 1; i <= nclk; i++) begin
      if (i == 11 && ack) dev_d_low = 1'b1;
      dev_c_low = 1'b1;
      if (i == 1) t1 = cyc;
      repeat (50) @(negedge clk);
      if (i <= 10) bits[i-1] = d_line;
      dev_c_low = 1'b0;
      repeat (50) @(negedge clk);
    end
    dev_d_low = 1'b0;
  endtask

  logic [9:0] bits;
  int         t1, d0, e0, i0;
  bit         ok;

  initial begin
    tx_if.tx_data  = 8'h00;
    tx_if.tx_valid = 1'b0;
    #1;
    chk("rst_c_oe", {31'd0, c_oe}, 0);
    chk("rst_d_oe", {31'd0, d_oe}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_ready", {31'd0, tx_if.tx_ready}, 1);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_code", {30'd0, code}, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    // 0xED with ACK
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'hED);
    dev_frame(1'b1, 11, bits, t1, ok);
    chk("ed_dev_ok", {31'd0, ok}, 1);
    wait_idle(2000, "ed_idle");
    chk("ed_bits_lit", {22'd0, bits}, 32'h3ED);
    chk("ed_bits_mdl", {22'd0, bits}, {22'd0, frame_of(8'hED)});
    chk("ed_inhibit", last_inh, 100);
    chk("ed_done", done_cnt - d0, 1);
    chk("ed_noerr", err_cnt - e0, 0);

    // 0x00 and 0x07 with ACK (parity 1 and 0)
    send(8'h00);
    dev_frame(1'b1, 11, bits, t1, ok);
    chk("z_dev_ok", {31'd0, ok}, 1);
    wait_idle(2000, "z_idle");
    chk("z_bits_lit", {22'd0, bits}, 32'h300);
    chk("z_parity", {31'd0, bits[8]}, 1);
    chk("z_done", done_cnt - d0, 2);
    send(8'h07);
    dev_frame(1'b1, 11, bits, t1, ok);
    chk("s7_dev_ok", {31'd0, ok}, 1);
    wait_idle(2000, "s7_idle");
    chk("s7_bits_lit", {22'd0, bits}, 32'h207);
    chk("s7_bits_mdl", {22'd0, bits}, {22'd0, frame_of(8'h07)});
    chk("s7_done", done_cnt - d0, 3);

    // silent device: start timeout
    e0 = err_cnt;
    i0 = inh_cnt;
    send(8'h5A);
    wait_idle(70000, "st_idle");
    chk("st_err", err_cnt - e0, 1);
    chk("st_code", {30'd0, last_code}, 1);
    chk("st_time", t_err - t_rts, 15000);
    chk("st_phases", inh_cnt - i0, TRIES);
    chk("st_lines", {30'd0, c_oe, d_oe}, 0);

    // device never ACKs
    e0 = err_cnt;
    i0 = inh_cnt;
    send(8'hA5);
    for (int k = 0; k < TRIES; k++) begin
      dev_frame(1'b0, 11, bits, t1, ok);
      chk("na_dev_ok", {31'd0, ok}, 1);
      chk("na_bits", {22'd0, bits}, {22'd0, frame_of(8'hA5)});
    end
    wait_idle(2000, "na_idle");
    chk("na_err", err_cnt - e0, 1);
    chk("na_code", {30'd0, last_code}, 3);
    chk("na_phases", inh_cnt - i0, TRIES);

    // device stops after 5 edges: transfer timeout
    e0 = err_cnt;
    i0 = inh_cnt;
    send(8'h3C);
    dev_frame(1'b1, 5, bits, t1, ok);
    chk("xt_dev_ok", {31'd0, ok}, 1);
    wait_idle(5000, "xt_idle");
    chk("xt_err", err_cnt - e0, 1);
    chk("xt_code", {30'd0, last_code}, 2);
    chk("xt_time", t_err - t1, 2003);
    chk("xt_phases", inh_cnt - i0, 1);

    // reset in the middle of the data bits
    i0 = inh_cnt;
    send(8'h00);
    fork
      dev_frame(1'b1, 4, bits, t1, ok);
      begin
        for (int n = 0; n < 400 && inh_cnt == i0; n++) @(negedge clk);
        repeat (300) @(negedge clk);
        chk("pr_busy", {31'd0, busy}, 1);
        chk("pr_d_oe", {31'd0, d_oe}, 1);
        rstn = 1'b0;
        #1;
        chk("ar_c_oe", {31'd0, c_oe}, 0);
        chk("ar_d_oe", {31'd0, d_oe}, 0);
        chk("ar_ready", {31'd0, tx_if.tx_ready}, 1);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
      end
    join
    repeat (20) @(negedge clk);
    chk("ar_ignore", {31'd0, busy}, 0);

    // request while busy is dropped
    d0 = done_cnt;
    i0 = inh_cnt;
    send(8'h00);
    fork
      dev_frame(1'b1, 11, bits, t1, ok);
      begin
        repeat (20) @(negedge clk);
        chk("bz_ready", {31'd0, tx_if.tx_ready}, 0);
        tx_if.tx_data  = 8'hFF;
        tx_if.tx_valid = 1'b1;
        @(negedge clk);
        tx_if.tx_valid = 1'b0;
      end
    join
    wait_idle(2000, "bz_idle");
    repeat (300) @(negedge clk);
    chk("bz_dev_ok", {31'd0, ok}, 1);
    chk("bz_bits", {22'd0, bits}, 32'h300);
    chk("bz_frames", inh_cnt - i0, 1);
    chk("bz_done", done_cnt - d0, 1);
    chk("bz_quiet", {31'd0, busy}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
